// File: rtl/irrigation_sequencer.sv
// Multi-zone irrigation sequencer: round-robin zone arbitration, self-timed
// FILL / SPRINKLER / DRIP / CLEAN phases, Moore-decoded pump and valve drives.
module irrigation_sequencer #(
  parameter int ZONES       = 4,
  parameter int TW          = 8,
  parameter int FILL_TICKS  = 20,
  parameter int CLEAN_TICKS = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [ZONES-1:0]           zone_req,
  input  logic [ZONES-1:0]           zone_drip,
  input  logic [ZONES-1:0]           zone_specific,
  input  logic [TW-1:0]              duration,
  input  logic                       abort,
  output logic [2:0]                 state,
  output logic [$clog2(ZONES)-1:0]   active_zone,
  output logic [ZONES-1:0]           zone_valve,
  output logic                       pump,
  output logic                       sprinkler_on,
  output logic                       drip_on,
  output logic                       busy,
  output logic                       done,
  output logic [ZONES-1:0]           pending
);

  localparam int ZW = $clog2(ZONES);
  localparam logic [TW-1:0] FILL_LIM  = TW'(FILL_TICKS);
  localparam logic [TW-1:0] CLEAN_LIM = TW'(CLEAN_TICKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_SPRK  = 3'd2,
    S_DRIP  = 3'd3,
    S_CLEAN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    M_SPRK = 2'd0,
    M_DRIP = 2'd1,
    M_SPEC = 2'd2
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    dur_q, dur_d;
  logic [TW-1:0]    limit_s;
  logic [ZONES-1:0] pending_q, pending_d;
  logic [ZONES-1:0] zone_oh_s, clr_mask_s;
  logic [ZW-1:0]    zone_q, zone_d;
  logic [ZW-1:0]    rr_q, rr_d;
  logic [ZW-1:0]    pick_idx_s;
  logic             pick_found_s;
  logic             done_q, done_d;
  logic             phase_end_s, job_end_s, run_s, abort_s;

  // First set request strictly after ptr, wrapping; MSB of result = found.
  function automatic logic [ZW:0] rr_pick(input logic [ZONES-1:0] req,
                                          input logic [ZW-1:0] ptr);
    logic          found;
    logic [ZW-1:0] idx;
    logic [ZW-1:0] cand;
    int            s;
    found = 1'b0;
    idx   = {ZW{1'b0}};
    for (int i = 1; i <= ZONES; i++) begin
      s     = int'(ptr) + i;
      s     = (s >= ZONES) ? (s - ZONES) : s;
      cand  = s[ZW-1:0];
      idx   = (!found && req[cand]) ? cand : idx;
      found = found | req[cand];
    end
    return {found, idx};
  endfunction

  function automatic logic [ZONES-1:0] onehot(input logic [ZW-1:0] idx);
    return {{(ZONES-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign {pick_found_s, pick_idx_s} = rr_pick(pending_q, rr_q);
  assign zone_oh_s   = onehot(zone_q);
  assign run_s       = (state_q == S_FILL) || (state_q == S_SPRK) || (state_q == S_DRIP);
  assign abort_s     = abort && run_s;
  assign phase_end_s = tick && (({1'b0, cnt_q} + {{TW{1'b0}}, 1'b1}) == {1'b0, limit_s});
  assign job_end_s   = (state_q == S_CLEAN) && phase_end_s;
  assign clr_mask_s  = (job_end_s || abort_s) ? zone_oh_s : {ZONES{1'b0}};

  // Tick limit of the phase currently running.
  always_comb begin
    case (state_q)
      S_FILL:         limit_s = FILL_LIM;
      S_SPRK, S_DRIP: limit_s = dur_q;
      S_CLEAN:        limit_s = CLEAN_LIM;
      default:        limit_s = {TW{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort pre-empts phase completion but never CLEAN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) state_d = S_FILL;
        else              state_d = S_IDLE;
      end
      S_FILL: begin
        if (abort)            state_d = S_CLEAN;
        else if (phase_end_s) state_d = (mode_q == M_DRIP) ? S_DRIP : S_SPRK;
        else                  state_d = S_FILL;
      end
      S_SPRK: begin
        if (abort)            state_d = S_CLEAN;
        else if (phase_end_s) state_d = (mode_q == M_SPEC) ? S_DRIP : S_CLEAN;
        else                  state_d = S_SPRK;
      end
      S_DRIP: begin
        if (abort || phase_end_s) state_d = S_CLEAN;
        else                      state_d = S_DRIP;
      end
      S_CLEAN: begin
        if (phase_end_s) state_d = S_IDLE;
        else             state_d = S_CLEAN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job datapath: phase counter, pending set/clear, job parameters latched at selection.
  always_comb begin
    pending_d = (pending_q & ~clr_mask_s) | zone_req;
    done_d    = job_end_s;
    if (state_d != state_q) begin
      cnt_d = {TW{1'b0}};
    end else if (tick && (state_q != S_IDLE)) begin
      cnt_d = cnt_q + TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if ((state_q == S_IDLE) && pick_found_s) begin
      zone_d = pick_idx_s;
      rr_d   = pick_idx_s;
      dur_d  = (duration == {TW{1'b0}}) ? TW'(1) : duration;
      mode_d = zone_specific[pick_idx_s] ? M_SPEC :
               (zone_drip[pick_idx_s] ? M_DRIP : M_SPRK);
    end else begin
      zone_d = zone_q;
      rr_d   = rr_q;
      dur_d  = dur_q;
      mode_d = mode_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= {TW{1'b0}};
      dur_q     <= {TW{1'b0}};
      pending_q <= {ZONES{1'b0}};
      zone_q    <= {ZW{1'b0}};
      rr_q      <= ZW'(ZONES - 1);
      mode_q    <= M_SPRK;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dur_q     <= dur_d;
      pending_q <= pending_d;
      zone_q    <= zone_d;
      rr_q      <= rr_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    pump         = 1'b0;
    sprinkler_on = 1'b0;
    drip_on      = 1'b0;
    zone_valve   = {ZONES{1'b0}};
    case (state_q)
      S_FILL: begin
        pump = 1'b1;
      end
      S_SPRK: begin
        pump         = 1'b1;
        sprinkler_on = 1'b1;
        zone_valve   = zone_oh_s;
      end
      S_DRIP: begin
        pump       = 1'b1;
        drip_on    = 1'b1;
        zone_valve = zone_oh_s;
      end
      default: begin
        pump = 1'b0;
      end
    endcase
  end

  assign state       = state_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign pending     = pending_q;
  assign active_zone = zone_q;

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
Parametrised multi-zone irrigation controller that supersedes the single-channel fill/sprinkler/drip/clean state machine. It owns its own phase timers, so no external time_over signal is needed. Zones are served one at a time by a round-robin arbiter. It sits between the sensor/request logic and the pump and valve drivers.

Parameters:
ZONES, 4, number of irrigation zones (2..16)
TW, 8, width of phase tick counters and of the duration input
FILL_TICKS, 20, ticks spent in FILL before irrigating
CLEAN_TICKS, 10, ticks spent in CLEAN after irrigating

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high
tick  in  1  timebase enable; counters advance only when 1
zone_req  in  ZONES  per-zone request pulse/level; sets pending bit
zone_drip  in  ZONES  mode select per zone: 1 = drip, 0 = sprinkler
zone_specific  in  ZONES  1 = sprinkler phase followed by drip phase (overrides zone_drip)
duration  in  TW  irrigation phase length in ticks, sampled at job start
abort  in  1  ends current job early via CLEAN
state  out  3  0 IDLE, 1 FILL, 2 SPRINKLER, 3 DRIP, 4 CLEAN
active_zone  out  clog2(ZONES)  index of zone being served
zone_valve  out  ZONES  one-hot valve of active_zone during SPRINKLER/DRIP, else 0
pump  out  1  1 in FILL, SPRINKLER, DRIP
sprinkler_on  out  1  1 in SPRINKLER
drip_on  out  1  1 in DRIP
busy  out  1  1 whenever state != IDLE
done  out  1  one-cycle pulse on CLEAN -> IDLE
pending  out  ZONES  latched outstanding requests

Behaviour:
- Reset (synchronous): state=IDLE, pending=0, counter=0, active_zone=0, rr pointer=last index (ZONES-1). All outputs 0.
- Pending: bit i is set on any cycle with zone_req[i]=1. It is cleared on the cycle of that zone's job completion (CLEAN->IDLE) or abort. A set on the same cycle as a clear wins, so the request is re-queued.
- Arbiter: in IDLE with pending!=0, select the first set bit searching upward from rr pointer+1 with wrap. Next cycle enters FILL.
- At selection, latch: active_zone; mode = zone_specific ? SPEC : (zone_drip ? DRIP : SPRK); dur = (duration==0) ? 1 : duration. Set rr pointer=active_zone. Later changes to the inputs do not affect the running job.
- Phase counter: reset to 0 on every state change. It increments on tick. A phase ends on the tick where counter+1 == limit, and the state changes on that clock edge. Limits: FILL uses FILL_TICKS, SPRINKLER/DRIP use dur, CLEAN uses CLEAN_TICKS.
- Transitions:
  - FILL -> SPRINKLER if mode SPRK or SPEC, else DRIP.
  - SPRINKLER -> DRIP if mode SPEC, else CLEAN.
  - DRIP -> CLEAN.
  - CLEAN -> IDLE with done=1 for exactly that cycle; pending[active_zone] is cleared.
  - No tick means no progress; the state is held indefinitely.
- Abort: sampled every cycle.
  - In FILL/SPRINKLER/DRIP: next state CLEAN, counter=0, pending[active_zone] cleared immediately.
  - In CLEAN or IDLE: ignored. CLEAN always runs to completion.
- Back-to-back: IDLE lasts at least one cycle between jobs. Arbitration occurs in that IDLE cycle.
- Outputs are registered-state decodes (Moore). No combinational path from inputs to outputs except through state.
- active_zone holds its last value in IDLE. zone_valve is 0 in IDLE, FILL and CLEAN.
- Reset mid-job: everything returns to reset values on the next edge, and pending requests are lost.

Test Plan:
- Reset, then zone_req=4'b0010, zone_drip=0, duration=5, tick=1 constant -> IDLE 1 cycle, FILL 20 cycles, SPRINKLER 5 cycles with zone_valve=0010 and sprinkler_on=1, CLEAN 10 cycles, done pulse, pending=0.
- zone_specific[0]=1, duration=3 -> FILL 20, SPRINKLER 3, DRIP 3, CLEAN 10. zone_valve=0001 throughout SPRINKLER and DRIP.
- Requests on zones 0, 2, 3 simultaneously -> served in order 0, 2, 3. A re-request of zone 0 during zone 2's job is served after zone 3.
- tick toggled every 4th cycle, duration=2, zone_drip[1]=1 -> DRIP lasts exactly 2 ticks (8 clock cycles). State is held between ticks.
- abort asserted during the 2nd tick of SPRINKLER -> next state CLEAN, pump=0, pending bit cleared. CLEAN lasts full 10 ticks, then done.
- duration=0 -> irrigation phase lasts 1 tick. reset asserted in DRIP -> next cycle state=0, outputs 0, pending=0.
